// File: rtl/sparse_pair_feeder_if.sv
// Handshake bundle between upstream operand source, the sparse pair feeder and
// the 4-input adder tree. The master side drives groups in and accepts products.
interface sparse_pair_feeder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_w;
    logic [31:0] in_a;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_val0;
    logic [15:0] out_val1;
    logic [15:0] out_val2;
    logic [15:0] out_val3;
    logic [3:0]  out_sel;
    logic        out_last;

    modport master (
        output in_valid, in_w, in_a, in_last, out_ready,
        input  in_ready, out_valid, out_val0, out_val1, out_val2, out_val3,
               out_sel, out_last
    );

    modport slave (
        input  in_valid, in_w, in_a, in_last, out_ready,
        output in_ready, out_valid, out_val0, out_val1, out_val2, out_val3,
               out_sel, out_last
    );
endinterface

// File: rtl/sparse_pair_feeder.sv
// Two-stage feeder: masks zero lanes, forms signed 8x8 products for the adder tree.
// Define SPARSE_FEEDER_SKIP_ZERO_EN to drop all-zero, non-last groups and count them.
module sparse_pair_feeder (
    input  logic                 clk,
    input  logic                 rst_n,
    sparse_pair_feeder_if.slave  bus,
    output logic [15:0]          skip_cnt,
    output logic                 busy
);
    logic              r_a_valid;
    logic [31:0]       r_a_w;
    logic [31:0]       r_a_a;
    logic [3:0]        r_a_sel;
    logic              r_a_last;

    logic              r_b_valid;
    logic [3:0][15:0]  r_b_val;
    logic [3:0]        r_b_sel;
    logic              r_b_last;

    logic [3:0]        w_in_sel;
    logic [3:0][15:0]  w_prod;
    logic              w_b_load;
    logic              w_a_adv;
    logic              w_in_fire;
    logic              w_a_load;
    logic              w_skip;

    assign w_b_load  = !r_b_valid || bus.out_ready;
    assign w_a_adv   = r_a_valid && w_b_load;
    assign w_in_fire = bus.in_valid && bus.in_ready;
    assign w_a_load  = w_in_fire && !w_skip;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic signed [15:0] w_wx;
            logic signed [15:0] w_ax;
            assign w_in_sel[gi] = (bus.in_w[8*gi +: 8] != 8'd0) && (bus.in_a[8*gi +: 8] != 8'd0);
            // Widen before multiplying so the full signed product survives (-128*-128 fits).
            assign w_wx = {{8{r_a_w[8*gi+7]}}, r_a_w[8*gi +: 8]};
            assign w_ax = {{8{r_a_a[8*gi+7]}}, r_a_a[8*gi +: 8]};
            assign w_prod[gi] = r_a_sel[gi] ? 16'(w_wx * w_ax) : 16'd0;
        end
    endgenerate

`ifdef SPARSE_FEEDER_SKIP_ZERO_EN
    logic [15:0] r_skip_cnt;

    // A last group must always reach the tree so the pixel closes, even if empty.
    assign w_skip = (w_in_sel == 4'd0) && !bus.in_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip_cnt <= 16'd0;
        end else if (w_in_fire && w_skip && (r_skip_cnt != 16'hFFFF)) begin
            r_skip_cnt <= r_skip_cnt + 16'd1;
        end
    end

    assign skip_cnt = r_skip_cnt;
`else
    assign w_skip   = 1'b0;
    assign skip_cnt = 16'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
            r_a_w     <= 32'd0;
            r_a_a     <= 32'd0;
            r_a_sel   <= 4'd0;
            r_a_last  <= 1'b0;
        end else if (w_a_load) begin
            r_a_valid <= 1'b1;
            r_a_w     <= bus.in_w;
            r_a_a     <= bus.in_a;
            r_a_sel   <= w_in_sel;
            r_a_last  <= bus.in_last;
        end else if (w_a_adv) begin
            r_a_valid <= 1'b0;
        end
    end

    // Data only moves when a real group arrives, keeping out_* steady otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_valid <= 1'b0;
            r_b_val   <= '0;
            r_b_sel   <= 4'd0;
            r_b_last  <= 1'b0;
        end else if (w_b_load) begin
            r_b_valid <= r_a_valid;
            if (r_a_valid) begin
                r_b_val  <= w_prod;
                r_b_sel  <= r_a_sel;
                r_b_last <= r_a_last;
            end
        end
    end

    assign bus.in_ready  = !r_a_valid || w_b_load;
    assign bus.out_valid = r_b_valid;
    assign bus.out_val0  = r_b_val[0];
    assign bus.out_val1  = r_b_val[1];
    assign bus.out_val2  = r_b_val[2];
    assign bus.out_val3  = r_b_val[3];
    assign bus.out_sel   = r_b_sel;
    assign bus.out_last  = r_b_last;
    assign busy          = r_a_valid || r_b_valid;
endmodule

// File: tb/tb_sparse_pair_feeder.sv
// Directed, table-driven bench for sparse_pair_feeder: latency, masking, products,
// backpressure, zero-group skipping (either build) and mid-cycle reset.
module tb_sparse_pair_feeder;
    typedef struct {
        logic [31:0] w;
        logic [31:0] a;
        logic        last;
        logic [3:0]  sel;
        logic [15:0] v0;
        logic [15:0] v1;
        logic [15:0] v2;
        logic [15:0] v3;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] skip_cnt;
    logic        busy;
    int          total;
    int          bad;
    vec_t        tbl [5];

    sparse_pair_feeder_if bus ();

    sparse_pair_feeder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .skip_cnt (skip_cnt),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int k);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_sel"},   32'(bus.out_sel),   32'(tbl[k].sel));
        chk({tag, "_val0"},  32'(bus.out_val0),  32'(tbl[k].v0));
        chk({tag, "_val1"},  32'(bus.out_val1),  32'(tbl[k].v1));
        chk({tag, "_val2"},  32'(bus.out_val2),  32'(tbl[k].v2));
        chk({tag, "_val3"},  32'(bus.out_val3),  32'(tbl[k].v3));
        chk({tag, "_last"},  32'(bus.out_last),  32'(tbl[k].last));
    endtask

    task automatic drive(input logic [31:0] w, input logic [31:0] a, input logic last);
        bus.in_valid = 1'b1;
        bus.in_w     = w;
        bus.in_a     = a;
        bus.in_last  = last;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int recv;
        int exp_cnt;
        int exp_skip;
        logic in_fire;
        logic out_fire;

        total = 0;
        bad   = 0;
        tbl[0] = '{32'h01FF8002, 32'h03048005, 1'b1, 4'b1111, 16'h000A, 16'h4000, 16'hFFFC, 16'h0003};
        tbl[1] = '{32'h05000700, 32'h00090206, 1'b0, 4'b0010, 16'h0000, 16'h000E, 16'h0000, 16'h0000};
        tbl[2] = '{32'h7F7F8181, 32'h817F817F, 1'b1, 4'b1111, 16'hC0FF, 16'h3F01, 16'h3F01, 16'hC0FF};
        tbl[3] = '{32'h00000000, 32'h11223344, 1'b1, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[4] = '{32'h00FF8001, 32'h12FE7F00, 1'b0, 4'b0110, 16'h0000, 16'hC080, 16'h0002, 16'h0000};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_w      = 32'd0;
        bus.in_a      = 32'd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_skip_cnt",  32'(skip_cnt),      32'd0);
        chk("rst_out_sel",   32'(bus.out_sel),   32'd0);
        chk("rst_out_last",  32'(bus.out_last),  32'd0);
        chk("rst_out_val0",  32'(bus.out_val0),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        step();

        // Isolated vectors: latency and product/mask values.
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].w, tbl[i].a, tbl[i].last);
            @(negedge clk);
            chk("vec_in_ready", 32'(bus.in_ready), 32'd1);
            chk("vec_idle_out", 32'(bus.out_valid), 32'd0);
            step();
            bus.in_valid = 1'b0;
            @(negedge clk);
            chk("vec_lat1_out", 32'(bus.out_valid), 32'd0);
            step();
            @(negedge clk);
            check_out("vec", i);
            $display("vec %0d: w=%h a=%h sel=%b v=%h %h %h %h last=%b", i, tbl[i].w, tbl[i].a,
                     bus.out_sel, bus.out_val0, bus.out_val1, bus.out_val2, bus.out_val3, bus.out_last);
            step();
        end

        // Streaming with a backpressure window in cycles 3..6.
        sent = 0;
        recv = 0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            bus.out_ready = !(c >= 3 && c <= 6);
            if (sent < 6) drive(tbl[sent % 5].w, tbl[sent % 5].a, tbl[sent % 5].last);
            else bus.in_valid = 1'b0;
            @(negedge clk);
            if (c >= 3 && c <= 6) begin
                chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
                check_out("stall_hold", 1);
            end
            in_fire  = bus.in_valid && bus.in_ready;
            out_fire = bus.out_valid && bus.out_ready;
            if (out_fire) begin
                check_out("stream", recv % 5);
                $display("stream out %0d: sel=%b last=%b", recv, bus.out_sel, bus.out_last);
                recv++;
            end
            if (in_fire) sent++;
            step();
        end
        chk("stream_count", 32'(recv), 32'd6);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();

        // Three all-zero non-last groups followed by a real last group.
`ifdef SPARSE_FEEDER_SKIP_ZERO_EN
        exp_cnt  = 1;
        exp_skip = 3;
`else
        exp_cnt  = 4;
        exp_skip = 0;
`endif
        sent = 0;
        recv = 0;
        for (int c = 0; c < 20; c++) begin
            if (sent < 3) drive(32'h00000000, 32'h01020304, 1'b0);
            else if (sent == 3) drive(tbl[0].w, tbl[0].a, tbl[0].last);
            else bus.in_valid = 1'b0;
            @(negedge clk);
            if (sent < 4) chk("skip_in_ready", 32'(bus.in_ready), 32'd1);
            in_fire  = bus.in_valid && bus.in_ready;
            out_fire = bus.out_valid && bus.out_ready;
            if (out_fire) begin
                recv++;
                if (recv == exp_cnt) check_out("skip_final", 0);
                $display("skip test out %0d: sel=%b last=%b", recv, bus.out_sel, bus.out_last);
            end
            if (in_fire) sent++;
            step();
        end
        chk("skip_out_count", 32'(recv), 32'(exp_cnt));
        chk("skip_cnt_value", 32'(skip_cnt), 32'(exp_skip));

        // Fill both stages under backpressure, then reset mid-cycle.
        bus.out_ready = 1'b0;
        drive(tbl[2].w, tbl[2].a, tbl[2].last);
        step();
        drive(tbl[4].w, tbl[4].a, tbl[4].last);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("full_busy",     32'(busy),          32'd1);
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        chk("full_in_ready", 32'(bus.in_ready),  32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_busy",      32'(busy),          32'd0);
        chk("midrst_skip_cnt",  32'(skip_cnt),      32'd0);
        chk("midrst_out_sel",   32'(bus.out_sel),   32'd0);
        chk("midrst_out_val1",  32'(bus.out_val1),  32'd0);
        chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        step();
        drive(tbl[1].w, tbl[1].a, tbl[1].last);
        @(negedge clk);
        chk("after_rst_lat0", 32'(bus.out_valid), 32'd0);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("after_rst_lat1", 32'(bus.out_valid), 32'd0);
        step();
        @(negedge clk);
        check_out("after_rst", 1);
        $display("after reset out: sel=%b val1=%h", bus.out_sel, bus.out_val1);
        step();
        @(negedge clk);
        chk("drained_out_valid", 32'(bus.out_valid), 32'd0);
        chk("drained_busy",      32'(busy),          32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
